// File: rtl/lc4_trace_pkg.sv
// Shared definitions for the LC4 commit tracer: stall codes, record layout and
// counter helpers.
package lc4_trace_pkg;

  localparam int CNT_W  = 32;
  localparam int PC_W   = 16;
  localparam int INSN_W = 16;
  localparam int WSEL_W = 3;
  localparam int NZP_W  = 3;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_CACHE  = 2'd1,
    STALL_BRANCH = 2'd2,
    STALL_LOAD   = 2'd3
  } stall_e;

  // Record layout, LSB first: dmem_data, dmem_addr, dmem_we, nzp_bits, nzp_we,
  // regfile_data, wsel, regfile_we, insn, pc.
  function automatic int rec_w(int w);
    return 57 + 2 * w;
  endfunction

  function automatic int off_dmem_addr(int w);
    return w;
  endfunction

  function automatic int off_dmem_we(int w);
    return w + 16;
  endfunction

  function automatic int off_nzp_bits(int w);
    return w + 17;
  endfunction

  function automatic int off_nzp_we(int w);
    return w + 20;
  endfunction

  function automatic int off_rf_data(int w);
    return w + 21;
  endfunction

  function automatic int off_wsel(int w);
    return 2 * w + 21;
  endfunction

  function automatic int off_rf_we(int w);
    return 2 * w + 24;
  endfunction

  function automatic int off_insn(int w);
    return 2 * w + 25;
  endfunction

  function automatic int off_pc(int w);
    return 2 * w + 41;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lc4_commit_tracer_if.sv
// Commit-record stream between the tracer (master) and its consumer (slave).
interface lc4_commit_tracer_if
  import lc4_trace_pkg::*;
#(
  parameter int WORD_SIZE = 64
) ();
  localparam int REC_W = rec_w(WORD_SIZE);

  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/lc4_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is forced to zero while
// empty so the output is clean out of reset.
module lc4_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lc4_commit_tracer.sv
// Commit-trace unit: classifies gwe-qualified cycles, packs retired instructions
// into canonical records for the stream FIFO, and tallies stall causes.
module lc4_commit_tracer
  import lc4_trace_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 trace_en,
  input  logic                 clr_stats,
  input  logic [1:0]           test_stall,
  input  logic [15:0]          test_cur_pc,
  input  logic [15:0]          test_cur_insn,
  input  logic                 test_regfile_we,
  input  logic [2:0]           test_regfile_wsel,
  input  logic [WORD_SIZE-1:0] test_regfile_data,
  input  logic                 test_nzp_we,
  input  logic [2:0]           test_nzp_new_bits,
  input  logic                 test_dmem_we,
  input  logic [15:0]          test_dmem_addr,
  input  logic [WORD_SIZE-1:0] test_dmem_data,
  lc4_commit_tracer_if.master  rec,
  output logic [CNT_W-1:0]     cnt_cycles,
  output logic [CNT_W-1:0]     cnt_exec,
  output logic [CNT_W-1:0]     cnt_cache,
  output logic [CNT_W-1:0]     cnt_branch,
  output logic [CNT_W-1:0]     cnt_load,
  output logic [CNT_W-1:0]     cnt_drop,
  output logic                 overflow
);
  localparam int REC_W    = rec_w(WORD_SIZE);
  localparam int O_DADDR  = off_dmem_addr(WORD_SIZE);
  localparam int O_DWE    = off_dmem_we(WORD_SIZE);
  localparam int O_NZP    = off_nzp_bits(WORD_SIZE);
  localparam int O_NZP_WE = off_nzp_we(WORD_SIZE);
  localparam int O_RDATA  = off_rf_data(WORD_SIZE);
  localparam int O_WSEL   = off_wsel(WORD_SIZE);
  localparam int O_RWE    = off_rf_we(WORD_SIZE);
  localparam int O_INSN   = off_insn(WORD_SIZE);
  localparam int O_PC     = off_pc(WORD_SIZE);

  stall_e           stall;
  logic             sample;
  logic             retire;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic [REC_W-1:0] rec_word;

  assign stall  = stall_e'(test_stall);
  assign sample = gwe && trace_en;
  assign retire = sample && (stall == STALL_NONE);
  assign pop    = rec.rec_valid && rec.rec_ready;
  assign drop   = retire && full && !pop;

  // Fields that the core leaves undefined when their write enable is low are
  // zeroed so identical commits always produce identical records.
  always_comb begin
    rec_word                       = '0;
    rec_word[O_PC +: PC_W]         = test_cur_pc;
    rec_word[O_INSN +: INSN_W]     = test_cur_insn;
    rec_word[O_RWE]                = test_regfile_we;
    if (test_regfile_we) begin
      rec_word[O_WSEL +: WSEL_W]     = test_regfile_wsel;
      rec_word[O_RDATA +: WORD_SIZE] = test_regfile_data;
    end
    rec_word[O_NZP_WE]             = test_nzp_we;
    if (test_nzp_we) rec_word[O_NZP +: NZP_W] = test_nzp_new_bits;
    rec_word[O_DWE]                = test_dmem_we;
    rec_word[O_DADDR +: ADDR_W]    = test_dmem_addr;
    rec_word[0 +: WORD_SIZE]       = test_dmem_data;
  end

  lc4_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (retire),
    .push_data (rec_word),
    .pop       (pop),
    .pop_data  (rec.rec_data),
    .full      (full),
    .empty     (empty)
  );

  assign rec.rec_valid = !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_cycles <= '0;
      cnt_exec   <= '0;
      cnt_cache  <= '0;
      cnt_branch <= '0;
      cnt_load   <= '0;
      cnt_drop   <= '0;
      overflow   <= 1'b0;
    end else if (clr_stats) begin
      cnt_cycles <= '0;
      cnt_exec   <= '0;
      cnt_cache  <= '0;
      cnt_branch <= '0;
      cnt_load   <= '0;
      cnt_drop   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (sample) begin
        cnt_cycles <= sat_inc(cnt_cycles);
        case (stall)
          STALL_NONE:   cnt_exec   <= sat_inc(cnt_exec);
          STALL_CACHE:  cnt_cache  <= sat_inc(cnt_cache);
          STALL_BRANCH: cnt_branch <= sat_inc(cnt_branch);
          STALL_LOAD:   cnt_load   <= sat_inc(cnt_load);
          default:      ;
        endcase
      end
      if (drop) begin
        cnt_drop <= sat_inc(cnt_drop);
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc4_commit_tracer.sv
// Randomized bench for lc4_commit_tracer against a queue-based reference model.
module tb_lc4_commit_tracer;
  localparam int W     = 64;
  localparam int DEPTH = 16;
  localparam int REC_W = 57 + 2 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         gwe, trace_en, clr_stats;
  logic [1:0]   test_stall;
  logic [15:0]  pc, insn, daddr;
  logic         rwe, nwe, dwe;
  logic [2:0]   wsel, nzp;
  logic [W-1:0] rdata, ddata;
  logic [31:0]  cnt_cycles, cnt_exec, cnt_cache, cnt_branch, cnt_load, cnt_drop;
  logic         overflow;

  lc4_commit_tracer_if #(.WORD_SIZE(W)) rec_if ();

  lc4_commit_tracer #(.WORD_SIZE(W), .DEPTH(DEPTH)) dut (
    .clk (clk), .rst (rst), .gwe (gwe), .trace_en (trace_en), .clr_stats (clr_stats),
    .test_stall (test_stall), .test_cur_pc (pc), .test_cur_insn (insn),
    .test_regfile_we (rwe), .test_regfile_wsel (wsel), .test_regfile_data (rdata),
    .test_nzp_we (nwe), .test_nzp_new_bits (nzp),
    .test_dmem_we (dwe), .test_dmem_addr (daddr), .test_dmem_data (ddata),
    .rec (rec_if),
    .cnt_cycles (cnt_cycles), .cnt_exec (cnt_exec), .cnt_cache (cnt_cache),
    .cnt_branch (cnt_branch), .cnt_load (cnt_load), .cnt_drop (cnt_drop),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [REC_W-1:0] q[$];
  logic [31:0] m_cycles, m_exec, m_cache, m_branch, m_load, m_drop;
  logic        m_ovf;

  function automatic logic [31:0] sat(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [REC_W-1:0] make_rec();
    return {pc, insn, rwe, (rwe ? wsel : 3'd0), (rwe ? rdata : {W{1'b0}}),
            nwe, (nwe ? nzp : 3'd0), dwe, daddr, ddata};
  endfunction

  task automatic model_clear();
    m_cycles = 0; m_exec = 0; m_cache = 0; m_branch = 0; m_load = 0; m_drop = 0;
    m_ovf = 1'b0;
  endtask

  task automatic rand_fields();
    pc    = 16'($urandom);
    insn  = 16'($urandom);
    rwe   = 1'($urandom);
    wsel  = 3'($urandom);
    rdata = {$urandom, $urandom};
    nwe   = 1'($urandom);
    nzp   = 3'($urandom);
    dwe   = 1'($urandom);
    daddr = 16'($urandom);
    ddata = {$urandom, $urandom};
  endtask

  // Advance one clock: update the model from the driven inputs, scoreboard any
  // pop against the head of the model queue, then sample #1 after the edge.
  task automatic step();
    bit sample, pop, retire, room;
    sample = gwe && trace_en;
    retire = sample && (test_stall == 2'd0);
    pop    = (q.size() > 0) && rec_if.rec_ready;
    if (pop) begin
      total++;
      if (rec_if.rec_data !== q[0])
        $display("FAIL pop_data got=%h exp=%h", rec_if.rec_data, q[0]);
      else passed++;
      void'(q.pop_front());
    end
    room = q.size() < DEPTH;
    if (retire && room) q.push_back(make_rec());
    if (clr_stats) model_clear();
    else begin
      if (sample) begin
        m_cycles = sat(m_cycles);
        case (test_stall)
          2'd0: m_exec   = sat(m_exec);
          2'd1: m_cache  = sat(m_cache);
          2'd2: m_branch = sat(m_branch);
          default: m_load = sat(m_load);
        endcase
      end
      if (retire && !room) begin
        m_drop = sat(m_drop);
        m_ovf  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int budget);
    gwe = 1'b0; clr_stats = 1'b0; rec_if.rec_ready = 1'b1;
    for (int i = 0; i < budget && q.size() > 0; i++) step();
    total++;
    if (rec_if.rec_valid !== 1'b0 || q.size() != 0)
      $display("FAIL drain_empty valid=%b model_left=%0d exp valid=0 left=0", rec_if.rec_valid, q.size());
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; gwe = 1'b1; trace_en = 1'b1; clr_stats = 1'b0; test_stall = 2'd0;
    rec_if.rec_ready = 1'b1;
    rand_fields();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; gwe = 1'b0;
    q.delete(); model_clear();
    total++;
    if ({rec_if.rec_valid, overflow} !== 2'b00 || rec_if.rec_data !== '0)
      $display("FAIL reset_outputs valid=%b ovf=%b data=%h exp 0", rec_if.rec_valid, overflow, rec_if.rec_data);
    else passed++;
    total++;
    if ({cnt_cycles, cnt_exec, cnt_cache, cnt_branch, cnt_load, cnt_drop} !== '0)
      $display("FAIL reset_counters cyc=%0d exec=%0d drop=%0d exp 0", cnt_cycles, cnt_exec, cnt_drop);
    else passed++;
  endtask

  task automatic test_retire();
    logic [REC_W-1:0] exp;
    gwe = 1'b1; test_stall = 2'd0; rec_if.rec_ready = 1'b1;
    rand_fields();
    pc = 16'h8200; insn = 16'h1234; rwe = 1'b1; wsel = 3'd5; rdata = 64'h7;
    exp = {16'h8200, 16'h1234, 1'b1, 3'd5, 64'h7, nwe, (nwe ? nzp : 3'd0), dwe, daddr, ddata};
    step();
    gwe = 1'b0;
    total++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== exp)
      $display("FAIL retire_record valid=%b data=%h exp=%h", rec_if.rec_valid, rec_if.rec_data, exp);
    else passed++;
    total++;
    if (cnt_exec !== 32'd1 || cnt_cycles !== 32'd1)
      $display("FAIL retire_counters exec=%0d cyc=%0d exp 1 1", cnt_exec, cnt_cycles);
    else passed++;
    drain(4);
  endtask

  task automatic test_canon();
    logic [REC_W-1:0] exp;
    gwe = 1'b1; test_stall = 2'd0; rec_if.rec_ready = 1'b0;
    rand_fields();
    rwe = 1'b0; wsel = 3'd6; rdata = 64'hFF; nwe = 1'b0; nzp = 3'b010;
    exp = {pc, insn, 1'b0, 3'd0, 64'h0, 1'b0, 3'd0, dwe, daddr, ddata};
    step();
    gwe = 1'b0;
    total++;
    if (rec_if.rec_data !== exp)
      $display("FAIL canon_record got=%h exp=%h", rec_if.rec_data, exp);
    else passed++;
    drain(4);
  endtask

  task automatic test_stall_mix();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    rec_if.rec_ready = 1'b1;
    clr_stats = 1'b1; gwe = 1'b0; step(); clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      gwe = (i != 3);
      test_stall = seq[i];
      step();
    end
    gwe = 1'b0;
    total++;
    if ({cnt_cycles, cnt_cache, cnt_branch, cnt_load, cnt_exec} !== {32'd4, 32'd1, 32'd1, 32'd1, 32'd1})
      $display("FAIL stall_mix cyc=%0d cache=%0d branch=%0d load=%0d exec=%0d exp 4 1 1 1 1",
               cnt_cycles, cnt_cache, cnt_branch, cnt_load, cnt_exec);
    else passed++;
    drain(4);
  endtask

  task automatic test_overflow();
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    rec_if.rec_ready = 1'b0; gwe = 1'b1; test_stall = 2'd0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      rand_fields();
      step();
    end
    gwe = 1'b0;
    total++;
    if (cnt_drop !== 32'd2 || overflow !== 1'b1 || cnt_exec !== 32'd18)
      $display("FAIL overflow_drop drop=%0d ovf=%b exec=%0d exp 2 1 18", cnt_drop, overflow, cnt_exec);
    else passed++;
    rec_if.rec_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    total++;
    if (rec_if.rec_valid !== 1'b0)
      $display("FAIL overflow_drain_valid got=%b exp=0", rec_if.rec_valid);
    else passed++;
    drain(2);
  endtask

  task automatic test_full_pop_clr();
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    rec_if.rec_ready = 1'b0; gwe = 1'b1; test_stall = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_fields();
      step();
    end
    rand_fields(); rec_if.rec_ready = 1'b1; step();
    rand_fields(); rec_if.rec_ready = 1'b0; step();
    total++;
    if (cnt_drop !== 32'd1 || overflow !== 1'b1)
      $display("FAIL full_pop_occupancy drop=%0d ovf=%b exp 1 1", cnt_drop, overflow);
    else passed++;
    rand_fields(); clr_stats = 1'b1; step(); clr_stats = 1'b0; gwe = 1'b0;
    total++;
    if ({cnt_cycles, cnt_exec, cnt_cache, cnt_branch, cnt_load, cnt_drop, overflow} !== '0)
      $display("FAIL clr_priority cyc=%0d exec=%0d drop=%0d ovf=%b exp 0", cnt_cycles, cnt_exec, cnt_drop, overflow);
    else passed++;
    drain(DEPTH + 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rand_fields();
      gwe              = ($urandom_range(0, 9) < 8);
      trace_en         = ($urandom_range(0, 9) < 9);
      test_stall       = 2'($urandom);
      rec_if.rec_ready = 1'($urandom);
      clr_stats        = ($urandom_range(0, 99) < 2);
      step();
      total++;
      if ({cnt_cycles, cnt_exec, cnt_cache, cnt_branch, cnt_load, cnt_drop, overflow} !==
          {m_cycles, m_exec, m_cache, m_branch, m_load, m_drop, m_ovf})
        $display("FAIL random_counters cyc=%0d/%0d exec=%0d/%0d drop=%0d/%0d ovf=%b/%b (got/exp)",
                 cnt_cycles, m_cycles, cnt_exec, m_exec, cnt_drop, m_drop, overflow, m_ovf);
      else passed++;
      total++;
      if (rec_if.rec_valid !== (q.size() > 0))
        $display("FAIL random_valid got=%b exp=%b", rec_if.rec_valid, q.size() > 0);
      else passed++;
    end
    trace_en = 1'b1; clr_stats = 1'b0;
    drain(DEPTH + 2);
  endtask

  task automatic test_reset_midop();
    rec_if.rec_ready = 1'b0; gwe = 1'b1; test_stall = 2'd0;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      step();
    end
    gwe = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (rec_if.rec_valid !== 1'b0 || rec_if.rec_data !== '0 || cnt_exec !== '0)
      $display("FAIL reset_midop valid=%b exec=%0d data=%h exp 0", rec_if.rec_valid, cnt_exec, rec_if.rec_data);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0; q.delete(); model_clear();
  endtask

  initial begin
    test_reset();
    test_retire();
    test_canon();
    test_stall_mix();
    test_overflow();
    test_full_pop_clr();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
